// File: rtl/bm_dag3_result_packer_pkg.sv
// Shared constants for the bm_dag3 result packer: default geometry and pointer sizing.
package bm_dag3_result_packer_pkg;

  localparam int unsigned BitsDef  = 2;
  localparam int unsigned PackDef  = 4;
  localparam int unsigned DepthDef = 2;

  // Index bits plus one wrap bit, so full and empty can be told apart.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bm_dag3_pack_fifo.sv
// Generic synchronous FIFO, async active-low reset. When empty, data_o holds the last popped word.
module bm_dag3_pack_fifo
  import bm_dag3_result_packer_pkg::*;
#(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = DepthDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = ptr_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] last_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             push_en, pop_en;
  logic [Width-1:0] head;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop_en  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_en = push_i & (~full_o | pop_en);
  assign head    = mem_q[rd_ptr_q[AddrW-1:0]];
  assign data_o  = empty_o ? last_q : head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        wr_ptr_q                   <= wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        last_q   <= head;
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/bm_dag3_result_packer.sv
// Packs Pack consecutive {out1,out0} samples into one word and queues words in a FIFO.
// Optional BM_DAG3_PACK_PARITY_EN adds a per-entry parity bit presented on out_parity_o.
module bm_dag3_result_packer
  import bm_dag3_result_packer_pkg::*;
#(
  parameter int unsigned Bits  = BitsDef,
  parameter int unsigned Pack  = PackDef,
  parameter int unsigned Depth = DepthDef
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic                         in_valid_i,
  input  logic [Bits-1:0]              in_out0_i,
  input  logic                         in_out1_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Pack*(Bits+1)-1:0]     out_data_o,
`ifdef BM_DAG3_PACK_PARITY_EN
  output logic                         overflow_o,
  output logic                         out_parity_o
`else
  output logic                         overflow_o
`endif
);

  localparam int unsigned LaneW    = Bits + 1;
  localparam int unsigned WordW    = Pack * LaneW;
  localparam int unsigned LaneCntW = $clog2(Pack);
`ifdef BM_DAG3_PACK_PARITY_EN
  localparam int unsigned FifoW    = WordW + 1;
`else
  localparam int unsigned FifoW    = WordW;
`endif

  logic [LaneCntW-1:0]         lane_q, lane_d;
  logic [(Pack-1)*LaneW-1:0]   pack_q, pack_d;
  logic                        ovf_q, ovf_d;
  logic [LaneW-1:0]            sample;
  logic [WordW-1:0]            word;
  logic [FifoW-1:0]            fifo_wdata, fifo_rdata;
  logic                        last_lane, push, pop, full, empty;

  assign sample    = {in_out1_i, in_out0_i};
  assign word      = {sample, pack_q};
  assign last_lane = (lane_q == LaneCntW'(Pack - 1));
  assign push      = in_valid_i & ~flush_i & last_lane;
  assign pop       = ~empty & out_ready_i;

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    ovf_d  = ovf_q | (push & full & ~pop);
    if (flush_i) begin
      lane_d = '0;
      pack_d = '0;
    end else if (in_valid_i) begin
      if (last_lane) begin
        lane_d = '0;
        pack_d = '0;
      end else begin
        pack_d[int'(lane_q)*LaneW +: LaneW] = sample;
        lane_d = lane_q + LaneCntW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lane_q <= '0;
      pack_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef BM_DAG3_PACK_PARITY_EN
  assign fifo_wdata   = {^word, word};
  assign out_parity_o = ~empty & fifo_rdata[WordW];
`else
  assign fifo_wdata   = word;
`endif

  bm_dag3_pack_fifo #(
    .Width (FifoW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid_o = ~empty;
  assign out_data_o  = fifo_rdata[WordW-1:0];
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_bm_dag3_result_packer.sv
// Scoreboard bench for bm_dag3_result_packer: a packing model pushes expected words,
// a negedge monitor pops and compares against the DUT outputs.
module tb_bm_dag3_result_packer;

  localparam int unsigned BITS  = 2;
  localparam int unsigned PACK  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned WW    = PACK * (BITS + 1);

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid, in_out1, flush, out_ready;
  logic [BITS-1:0] in_out0;
  logic            out_valid, overflow;
  logic [WW-1:0]   out_data;
`ifdef BM_DAG3_PACK_PARITY_EN
  logic            out_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bm_dag3_result_packer dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .in_valid_i   (in_valid),
    .in_out0_i    (in_out0),
    .in_out1_i    (in_out1),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
`ifdef BM_DAG3_PACK_PARITY_EN
    .overflow_o   (overflow),
    .out_parity_o (out_parity)
`else
    .overflow_o   (overflow)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [WW-1:0]   exp_q[$];
  logic [WW-1:0]   m_last = '0;
  logic [WW-1:0]   m_pack = '0;
  logic [WW-1:0]   m_word;
  int              m_lane = 0;
  logic            m_ovf = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_lane = 0;
      m_pack = '0;
      m_ovf  = 1'b0;
      m_last = '0;
      exp_q.delete();
    end else if (flush) begin
      m_lane = 0;
      m_pack = '0;
    end else if (in_valid) begin
      m_word = m_pack;
      m_word[m_lane*3 +: 3] = {in_out1, in_out0};
      if (m_lane == PACK - 1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_word);
        else m_ovf = 1'b1;
        m_lane = 0;
        m_pack = '0;
      end else begin
        m_pack = m_word;
        m_lane++;
      end
    end
  end

  // Monitor: pops happen here, one half-cycle before the edge that the DUT pops on.
  always @(negedge clock) begin
    logic          ev;
    logic [WW-1:0] ed;
    ev = (exp_q.size() != 0);
    ed = ev ? exp_q[0] : m_last;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_data", 32'(out_data), 32'(ed));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef BM_DAG3_PACK_PARITY_EN
    check("out_parity", 32'(out_parity), 32'(ev ? ^ed : 1'b0));
`endif
    if (ev && out_ready) m_last = exp_q.pop_front();
  end

  task automatic drive(input logic v, input logic [1:0] d0, input logic d1, input logic fl,
                       input logic rdy);
    in_valid  = v;
    in_out0   = d0;
    in_out1   = d1;
    flush     = fl;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 1'b0, rdy);
  endtask

  // Lanes given as {out1,out0}, lane 0 first.
  task automatic word(input logic [2:0] l0, l1, l2, l3, input logic rdy);
    drive(1'b1, l0[1:0], l0[2], 1'b0, rdy);
    drive(1'b1, l1[1:0], l1[2], 1'b0, rdy);
    drive(1'b1, l2[1:0], l2[2], 1'b0, rdy);
    drive(1'b1, l3[1:0], l3[2], 1'b0, rdy);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_out0 = '0; in_out1 = 1'b0; flush = 1'b0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // 1: basic packing, latency 1
    word(3'b001, 3'b110, 3'b011, 3'b100, 1'b1);
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h8F1);
    idle(1'b1, 1);
    check("t1_drained", 32'(out_valid), 32'd0);
    check("t1_hold", 32'(out_data), 32'h8F1);

    // 2: back-pressure, third word dropped
    word(3'b010, 3'b101, 3'b111, 3'b000, 1'b0);
    word(3'b100, 3'b011, 3'b001, 3'b110, 1'b0);
    word(3'b111, 3'b111, 3'b111, 3'b111, 1'b0);
    check("t2_overflow", 32'(overflow), 32'd1);
    idle(1'b0, 2);
    idle(1'b1, 2);
    check("t2_empty", 32'(out_valid), 32'd0);
    idle(1'b1, 1);

    // 3: full FIFO, push and pop in the same cycle
    do_reset();
    word(3'b001, 3'b010, 3'b011, 3'b100, 1'b0);
    word(3'b101, 3'b110, 3'b111, 3'b000, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b0, 2);
    check("t3_overflow", 32'(overflow), 32'd0);
    idle(1'b1, 3);
    check("t3_empty", 32'(out_valid), 32'd0);

    // 4: flush wins over a coincident sample
    drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
    word(3'b111, 3'b001, 3'b010, 3'b100, 1'b1);
    in_valid = 1'b0;
    check("t4_data", 32'(out_data), 32'h88F);
    idle(1'b1, 2);

    // 5: async reset mid-word with a word queued
    word(3'b011, 3'b011, 3'b011, 3'b011, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    do_reset();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    word(3'b110, 3'b111, 3'b101, 3'b000, 1'b1);
    in_valid = 1'b0;
    check("t5_data", 32'(out_data), 32'h17E);
    idle(1'b1, 2);

    // 6: continuous random stream with random back-pressure
    do_reset();
    for (int i = 0; i < 64; i++)
      drive(1'b1, 2'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    idle(1'b1, 4);
    check("t6_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
